// File: rtl/cache_mem_arbiter_if.sv
// Bundle of signals between the I-cache/D-cache miss logic, the arbiter and the
// single main-memory port.
interface cache_mem_arbiter_if #(
  parameter int BLK_WORDS = 4,
  parameter int ADDR_W    = 32
);
  localparam int BEAT_W = $clog2(BLK_WORDS);

  // Handshake: a cache raises *_req and holds it (with a stable address) until its
  // *_done pulse; each memory beat moves exactly in a cycle where mem_req && mem_ready,
  // read data is valid only alongside the owner's *_rvalid, and *_done lasts one cycle.
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_rvalid;
  logic [BEAT_W-1:0] ic_beat;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic              dc_rvalid;
  logic [BEAT_W-1:0] dc_beat;
  logic              dc_done;

  logic [31:0]       rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
    output ic_rvalid, ic_beat, ic_done, dc_rvalid, dc_beat, dc_done, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_ready, mem_rdata,
    input  ic_rvalid, ic_beat, ic_done, dc_rvalid, dc_beat, dc_done, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter giving the memory port to the I-cache or D-cache for one
// whole block burst at a time; state is visible on o_state (0 idle, 1 burst, 2 done).
module cache_mem_arbiter #(
  parameter int BLK_WORDS = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.slave  bus,
  output logic [1:0]          o_state
);
  localparam int BEAT_W = $clog2(BLK_WORDS);
  localparam int OFS_W  = BEAT_W + 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};

  if (BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_bad_blk_words
    $error("BLK_WORDS must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BEAT_W-1:0] r_beat;
  logic              r_owner_dc;
  logic              r_last_dc;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;

  logic              w_any_req;
  logic              w_grant_dc;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_beat_acc;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_beat_addr;

  // A tie goes to whichever cache was not served last; last_grant resets to IC,
  // so the first tie after reset lands on the D-cache.
  assign w_any_req   = bus.ic_req | bus.dc_req;
  assign w_grant_dc  = bus.dc_req & (~bus.ic_req | ~r_last_dc);
  assign w_req_addr  = w_grant_dc ? bus.dc_addr : bus.ic_addr;
  assign w_beat_acc  = (r_state == ST_BURST) & bus.mem_ready;
  assign w_last_beat = (r_beat == BEAT_W'(BLK_WORDS - 1));
  assign w_beat_addr = r_base | {{(ADDR_W-OFS_W){1'b0}}, r_beat, 2'b00};
  assign o_state     = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next = ST_BURST;
      ST_BURST: if (w_beat_acc && w_last_beat) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Owner, aligned base and direction are frozen at the grant edge so that the
  // caches may change their address/we inputs freely while a burst is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat     <= '0;
      r_owner_dc <= 1'b0;
      r_last_dc  <= 1'b0;
      r_we       <= 1'b0;
      r_base     <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_owner_dc <= w_grant_dc;
        r_base     <= w_req_addr & ALIGN_MASK;
        r_we       <= w_grant_dc & bus.dc_we;
        r_beat     <= '0;
      end
      if (w_beat_acc) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_last_dc <= r_owner_dc;
      end
    end
  end

  always_comb begin
    bus.ic_rvalid = 1'b0;
    bus.ic_beat   = '0;
    bus.ic_done   = 1'b0;
    bus.dc_rvalid = 1'b0;
    bus.dc_beat   = '0;
    bus.dc_done   = 1'b0;
    bus.rdata     = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      ST_BURST: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = r_we;
        bus.mem_addr = w_beat_addr;
        bus.rdata    = bus.mem_rdata;
        if (r_owner_dc) begin
          bus.dc_beat   = r_beat;
          bus.dc_rvalid = bus.mem_ready & ~r_we;
          bus.mem_wdata = bus.dc_wdata;
        end else begin
          bus.ic_beat   = r_beat;
          bus.ic_rvalid = bus.mem_ready & ~r_we;
        end
      end
      ST_DONE: begin
        bus.dc_done = r_owner_dc;
        bus.ic_done = ~r_owner_dc;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: transaction-level model checked every cycle, directed
// scenarios pinned with literal values, then a long randomized run.
module tb_cache_mem_arbiter;
  localparam int BLK = 4;
  localparam int AW  = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.BLK_WORDS(BLK), .ADDR_W(AW)) bus ();
  logic [1:0] dbg_state;

  cache_mem_arbiter #(.BLK_WORDS(BLK), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // D-cache write data is a combinational mux on dc_beat when mux_mode is set.
  logic        mux_mode  = 1'b0;
  logic [31:0] wdata_rnd = '0;
  logic [31:0] wblk [BLK];
  assign bus.dc_wdata = mux_mode ? wblk[bus.dc_beat] : wdata_rnd;

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit ic_done_last = 1'b0;
  bit dc_done_last = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] obs_wdata_q[$];
  logic [31:0] obs_stall_q[$];
  int          obs_done_q[$];
  int          done_cyc_q[$];
  int          obs_rv_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_burst, m_done, m_owner_dc, m_last_dc, m_we;
  int          m_left;
  logic [31:0] m_base;

  function automatic void model_reset();
    m_burst = 0; m_done = 0; m_owner_dc = 0; m_last_dc = 0; m_we = 0;
    m_left = 0; m_base = '0;
  endfunction

  function automatic void model_step();
    logic [31:0] a;
    if (m_burst) begin
      if (bus.mem_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_burst = 0;
          m_done  = 1;
        end
      end
    end else if (m_done) begin
      m_done    = 0;
      m_last_dc = m_owner_dc;
    end else if (bus.ic_req || bus.dc_req) begin
      if (bus.ic_req && bus.dc_req) m_owner_dc = !m_last_dc;
      else                          m_owner_dc = bus.dc_req;
      a       = m_owner_dc ? bus.dc_addr : bus.ic_addr;
      m_base  = a - (a % (BLK * 4));
      m_we    = m_owner_dc ? bus.dc_we : 1'b0;
      m_burst = 1;
      m_left  = BLK;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- compare process ----------------
  bit          e_req, e_we, e_icv, e_dcv, e_icd, e_dcd;
  logic [31:0] e_addr, e_wdata;
  int          e_icb, e_dcb, beat;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (!rst_n) model_reset();
      e_req = 0; e_we = 0; e_icv = 0; e_dcv = 0; e_icd = 0; e_dcd = 0;
      e_addr = '0; e_wdata = '0; e_icb = 0; e_dcb = 0;
      if (m_burst) begin
        beat   = BLK - m_left;
        e_req  = 1;
        e_addr = m_base + 32'(4 * beat);
        e_we   = m_we;
        if (m_owner_dc) begin
          e_dcb   = beat;
          e_dcv   = bus.mem_ready && !m_we;
          e_wdata = bus.dc_wdata;
        end else begin
          e_icb = beat;
          e_icv = bus.mem_ready && !m_we;
        end
      end else if (m_done) begin
        if (m_owner_dc) e_dcd = 1;
        else            e_icd = 1;
      end
      chk("mem_req",   64'(bus.mem_req),   64'(e_req));
      chk("ic_rvalid", 64'(bus.ic_rvalid), 64'(e_icv));
      chk("dc_rvalid", 64'(bus.dc_rvalid), 64'(e_dcv));
      chk("ic_done",   64'(bus.ic_done),   64'(e_icd));
      chk("dc_done",   64'(bus.dc_done),   64'(e_dcd));
      chk("ic_beat",   64'(bus.ic_beat),   64'(e_icb));
      chk("dc_beat",   64'(bus.dc_beat),   64'(e_dcb));
      if (!m_done) begin
        chk("mem_addr",  64'(bus.mem_addr),  64'(e_addr));
        chk("mem_we",    64'(bus.mem_we),    64'(e_we));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
      end
      if (e_icv || e_dcv) chk("rdata", 64'(bus.rdata), 64'(bus.mem_rdata));
      if (bus.mem_req && bus.mem_ready) begin
        obs_addr_q.push_back(bus.mem_addr);
        if (bus.mem_we) obs_wdata_q.push_back(bus.mem_wdata);
      end
      if (bus.mem_req && !bus.mem_ready) obs_stall_q.push_back(bus.mem_addr);
      if (bus.ic_rvalid || bus.dc_rvalid) obs_rv_cnt++;
      if (bus.ic_done) begin obs_done_q.push_back(0); done_cyc_q.push_back(cyc); end
      if (bus.dc_done) begin obs_done_q.push_back(1); done_cyc_q.push_back(cyc); end
      ic_done_last = bus.ic_done;
      dc_done_last = bus.dc_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
    bus.mem_rdata = $urandom;
    wdata_rnd     = $urandom;
  endtask

  task automatic idle_inputs();
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0;
    bus.mem_ready = 1; mux_mode = 0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic clear_obs();
    obs_addr_q.delete(); obs_wdata_q.delete(); obs_stall_q.delete();
    obs_done_q.delete(); done_cyc_q.delete(); exp_q.delete();
    obs_rv_cnt = 0;
  endtask

  task automatic wait_done(input bit dc, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dc ? dc_done_last : ic_done_last) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_in_time"}, 64'(ok), 64'(1));
  endtask

  task automatic cmp_list(input string name, input int which);
    int n;
    n = (which == 0) ? obs_addr_q.size() : (which == 1) ? obs_wdata_q.size() : obs_stall_q.size();
    chk({name, "_len"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk(name, 64'((which == 0) ? obs_addr_q[i] : (which == 1) ? obs_wdata_q[i] : obs_stall_q[i]),
          64'(exp_q[i]));
  endtask

  function automatic int done_at(input int idx);
    return (idx < done_cyc_q.size()) ? done_cyc_q[idx] : -1;
  endfunction

  // ---------------- stimulus ----------------
  int t0, ndone;

  initial begin
    idle_inputs();
    bus.mem_rdata = '0;
    for (int i = 0; i < BLK; i++) wblk[i] = '0;
    do_reset();

    // 1: single I-cache read burst, unaligned request address.
    clear_obs();
    tick();
    bus.ic_addr = 32'h8000_0014; bus.ic_req = 1; t0 = cyc + 1;
    wait_done(0, 20, "t1_done");
    bus.ic_req = 0;
    exp_q = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C};
    cmp_list("t1_addr", 0);
    chk("t1_done_latency", 64'(done_at(0) - t0), 64'(5));
    chk("t1_rvalid_cnt", 64'(obs_rv_cnt), 64'(4));

    // 2: simultaneous requests after reset -> DC, IC, DC, IC.
    do_reset();
    clear_obs();
    tick();
    bus.ic_addr = 32'h0000_0200; bus.dc_addr = 32'h0000_0100;
    bus.ic_req = 1; bus.dc_req = 1;
    ndone = 0;
    for (int i = 0; i < 80 && ndone < 4; i++) begin
      tick();
      if (dc_done_last) begin ndone++; bus.dc_req = 0; end
      if (ic_done_last) begin
        ndone++;
        if (ndone == 2) bus.dc_req = 1;
        else            bus.ic_req = 0;
      end
    end
    bus.ic_req = 0; bus.dc_req = 0;
    exp_q = '{32'd1, 32'd0, 32'd1, 32'd0};
    chk("t2_done_cnt", 64'(obs_done_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < obs_done_q.size(); i++)
      chk("t2_order", 64'(obs_done_q[i]), 64'(exp_q[i]));
    chk("t2_ic_after_dc", 64'(done_at(1) - done_at(0)), 64'(6));

    // 3: D-cache write-back, wdata selected by dc_beat.
    clear_obs();
    tick();
    for (int i = 0; i < BLK; i++) wblk[i] = 32'hA5A5_0000 + 32'(i * 32'h111);
    mux_mode = 1; bus.dc_addr = 32'h8000_2040; bus.dc_we = 1; bus.dc_req = 1;
    wait_done(1, 20, "t3_done");
    bus.dc_req = 0; bus.dc_we = 0;
    exp_q = '{32'h8000_2040, 32'h8000_2044, 32'h8000_2048, 32'h8000_204C};
    cmp_list("t3_addr", 0);
    exp_q = '{32'hA5A5_0000, 32'hA5A5_0111, 32'hA5A5_0222, 32'hA5A5_0333};
    cmp_list("t3_wdata", 1);
    chk("t3_no_rvalid", 64'(obs_rv_cnt), 64'(0));
    chk("t3_one_done", 64'(obs_done_q.size()), 64'(1));
    mux_mode = 0;

    // 4: three-cycle stall on beat 2.
    clear_obs();
    tick();
    bus.ic_addr = 32'h0000_0A04; bus.ic_req = 1; t0 = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      bus.mem_ready = !((cyc + 1 >= t0 + 3) && (cyc + 1 <= t0 + 5));
      if (ic_done_last) break;
    end
    bus.mem_ready = 1; bus.ic_req = 0;
    exp_q = '{32'h0000_0A00, 32'h0000_0A04, 32'h0000_0A08, 32'h0000_0A0C};
    cmp_list("t4_addr", 0);
    exp_q = '{32'h0000_0A08, 32'h0000_0A08, 32'h0000_0A08};
    cmp_list("t4_stall_addr", 2);
    chk("t4_done_latency", 64'(done_at(0) - t0), 64'(8));

    // 5: reset during beat 1, then the held request completes from scratch.
    tick();
    bus.ic_addr = 32'h0000_3000; bus.ic_req = 1;
    repeat (2) tick();
    rst_n = 0;
    #1;
    chk("t5_rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("t5_rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("t5_rst_rvalid", 64'(bus.ic_rvalid), 64'(0));
    repeat (2) tick();
    rst_n = 1;
    clear_obs();
    t0 = cyc + 1;
    wait_done(0, 20, "t5_done");
    bus.ic_req = 0;
    exp_q = '{32'h0000_3000, 32'h0000_3004, 32'h0000_3008, 32'h0000_300C};
    cmp_list("t5_addr", 0);
    chk("t5_done_latency", 64'(done_at(0) - t0), 64'(5));

    // 6a: dc_addr / dc_we scribbled mid-burst must not disturb the latched burst.
    clear_obs();
    tick();
    bus.dc_addr = 32'h0000_123C; bus.dc_we = 0; bus.dc_req = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.dc_addr = $urandom; bus.dc_we = 1'($urandom_range(0, 1));
      if (dc_done_last) break;
    end
    bus.dc_req = 0; bus.dc_we = 0;
    exp_q = '{32'h0000_1230, 32'h0000_1234, 32'h0000_1238, 32'h0000_123C};
    cmp_list("t6_addr", 0);
    chk("t6_rvalid_cnt", 64'(obs_rv_cnt), 64'(4));

    // 6b: continuous I-cache request -> back-to-back bursts one idle cycle apart.
    clear_obs();
    tick();
    bus.ic_addr = 32'h0000_0040; bus.ic_req = 1; t0 = cyc + 1; ndone = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      tick();
      if (ic_done_last) ndone++;
    end
    bus.ic_req = 0;
    chk("t6_done1", 64'(done_at(0) - t0), 64'(5));
    chk("t6_done2", 64'(done_at(1) - t0), 64'(11));
    chk("t6_done3", 64'(done_at(2) - t0), 64'(17));

    // Randomized traffic with stalls, tie-breaks and occasional resets.
    for (int i = 0; i < BLK; i++) wblk[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (n == 1500) mux_mode = 1;
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.ic_addr   = $urandom;
      bus.dc_addr   = $urandom;
      bus.dc_we     = 1'($urandom_range(0, 1));
      if (ic_done_last)     bus.ic_req = ($urandom_range(0, 3) == 0);
      else if (!bus.ic_req) bus.ic_req = ($urandom_range(0, 2) == 0);
      if (dc_done_last)     bus.dc_req = ($urandom_range(0, 3) == 0);
      else if (!bus.dc_req) bus.dc_req = ($urandom_range(0, 2) == 0);
    end
    rst_n = 1;
    idle_inputs();
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    n_miss++;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end
endmodule
